// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and helpers for the mux_scan_sel block.
//   state_e   - control FSM states (manual select, auto-scan, frozen)
//   sel_width - select width for an N-channel mux, never below one bit
package mux_scan_pkg;

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StScan   = 2'd1,
    StFrozen = 2'd2
  } state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// mux_scan_sel_if: channel data, control and result signals of mux_scan_sel.
//   data_in  - N channels of W bits, channel k at [k*W +: W]
//   sel      - manual channel select
//   mode     - 0 manual, 1 auto-scan
//   hold     - freeze outputs and scan position
//   data_out - registered selected channel data
//   ch_out   - channel currently driving data_out
//   step     - one-cycle pulse on each scan advance
//   sel_err  - registered flag, manual sel out of range
// master drives the controls (environment side), slave is the mux itself.
interface mux_scan_sel_if #(
  parameter int unsigned W = 2,
  parameter int unsigned N = 4
);
  localparam int unsigned SW = mux_scan_pkg::sel_width(N);

  logic [N*W-1:0] data_in;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           hold;
  logic [W-1:0]   data_out;
  logic [SW-1:0]  ch_out;
  logic           step;
  logic           sel_err;

  modport master (
    output data_in, sel, mode, hold,
    input  data_out, ch_out, step, sel_err
  );

  modport slave (
    input  data_in, sel, mode, hold,
    output data_out, ch_out, step, sel_err
  );
endinterface

// File: rtl/scan_tick_div.sv
// scan_tick_div: scan-rate divider counting 0..SCAN_DIV-1.
//   clk_i  - clock
//   rst_ni - synchronous active-low reset
//   clr_i  - clear count to zero (wins over en_i)
//   en_i   - count enable; a disabled divider holds its count
//   tick_o - high in the enabled cycle the count sits at SCAN_DIV-1 (it wraps on that edge)
module scan_tick_div #(
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned     CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   LastCnt = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-way channel mux with manual select, auto-scan and hold.
//   CLOCK_50 - sole clock, rising edge
//   Resetn   - synchronous active-low reset, overrides hold and mode
//   bus      - mux_scan_sel_if slave (data_in, sel, mode, hold in;
//              data_out, ch_out, step, sel_err out)
// Optional feature macro MUX_SCAN_SEL_AUTOSCAN_EN: when defined, mode=1 selects the
// auto-scan state with its divider and step pulse; when undefined, mode is ignored and
// step stays 0.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int unsigned W        = 2,
  parameter int unsigned N        = 4,
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input logic           CLOCK_50,
  input logic           Resetn,
  mux_scan_sel_if.slave bus
);
  localparam int unsigned    SW     = sel_width(N);
  localparam logic [SW:0]    NumCh  = (SW + 1)'(N);
  localparam logic [SW-1:0]  LastCh = SW'(N - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  logic          sel_ok;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] din, input logic [SW-1:0] c);
    return din[c*W +: W];
  endfunction

  assign sel_ok = ({1'b0, bus.sel} < NumCh);

`ifdef MUX_SCAN_SEL_AUTOSCAN_EN
  logic          div_clr, div_en, div_tick;
  logic [SW-1:0] sel_clamp, scan_cur, scan_nxt;

  assign sel_clamp = sel_ok ? bus.sel : LastCh;
  // A channel inherited from an out-of-range manual select (via FROZEN) is pulled in range.
  assign scan_cur  = ({1'b0, ch_q} < NumCh) ? ch_q : LastCh;
  assign scan_nxt  = !div_tick ? scan_cur : ((scan_cur == LastCh) ? '0 : scan_cur + 1'b1);

  scan_tick_div #(
    .SCAN_DIV (SCAN_DIV)
  ) u_div (
    .clk_i  (CLOCK_50),
    .rst_ni (Resetn),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .tick_o (div_tick)
  );
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    step_d  = 1'b0;
    err_d   = err_q;
`ifdef MUX_SCAN_SEL_AUTOSCAN_EN
    div_clr = 1'b0;
    div_en  = 1'b0;
    if (bus.hold)      state_d = StFrozen;
    else if (bus.mode) state_d = StScan;
    else               state_d = StManual;
`else
    state_d = bus.hold ? StFrozen : StManual;
`endif

    // Actions follow the state being entered this edge.
    unique case (state_d)
      StFrozen: begin
        // everything holds, divider included
      end
      StManual: begin
        ch_d   = bus.sel;
        data_d = sel_ok ? pick(bus.data_in, bus.sel) : '0;
        err_d  = !sel_ok;
`ifdef MUX_SCAN_SEL_AUTOSCAN_EN
        div_clr = 1'b1;
`endif
      end
`ifdef MUX_SCAN_SEL_AUTOSCAN_EN
      StScan: begin
        err_d = 1'b0;
        if (state_q == StManual) begin
          ch_d    = sel_clamp;
          data_d  = pick(bus.data_in, sel_clamp);
          div_clr = 1'b1;
        end else begin
          // Running or resuming from FROZEN: keep the retained count and channel.
          div_en = 1'b1;
          ch_d   = scan_nxt;
          data_d = pick(bus.data_in, scan_nxt);
          step_d = div_tick;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q <= StManual;
      data_q  <= '0;
      ch_q    <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.ch_out   = ch_q;
  assign bus.step     = step_q;
  assign bus.sel_err  = err_q;
endmodule

// File: doc/mux_scan_sel.md
MUX_SCAN_SEL -- requirements
Module: mux_scan_sel

Interface
REQ-001 Parameter W, default 2: bit width of each data channel, W >= 1.
REQ-002 Parameter N, default 4: number of channels, 2 <= N <= 16; SW = max(1, clog2(N)).
REQ-003 Parameter SCAN_DIV, default 50_000_000: CLOCK_50 cycles per scan step, SCAN_DIV >= 2.
REQ-004 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  synchronous, active-low reset.
REQ-006 data_in  input  N*W  channel k occupies bits [k*W +: W].
REQ-007 sel  input  SW  manual channel select.
REQ-008 mode  input  1  0 = manual, 1 = auto-scan.
REQ-009 hold  input  1  1 = freeze outputs and scan position.
REQ-010 data_out  output  W  registered selected channel data.
REQ-011 ch_out  output  SW  channel currently driving data_out.
REQ-012 step  output  1  one-cycle pulse when scan advances ch_out.
REQ-013 sel_err  output  1  registered flag: manual sel >= N.

Function
REQ-014 FSM states MANUAL, SCAN, FROZEN; state, ch_out, data_out, step, sel_err and the divider count are all registered.
REQ-015 MANUAL: each cycle ch_out <= sel, data_out <= data_in[sel]; latency one cycle from sel/data_in change to data_out.
REQ-016 MANUAL with sel >= N: data_out <= 0, ch_out <= sel, sel_err <= 1; otherwise sel_err <= 0.
REQ-017 SCAN: divider counts 0..SCAN_DIV-1; in the cycle it reaches SCAN_DIV-1 it wraps to 0, ch_out advances, and step = 1 for that cycle.
REQ-018 Channel advance wraps N-1 -> 0; ch_out never takes a value >= N in SCAN.
REQ-019 SCAN: data_out <= data_in[ch_out next value] every cycle, so data_out tracks live data on the current channel.
REQ-020 SCAN: sel_err <= 0.
REQ-021 Transitions, priority highest first: hold=1 -> FROZEN; mode=1 -> SCAN; mode=0 -> MANUAL; evaluated every cycle.
REQ-022 MANUAL->SCAN: scan starts at min(sel, N-1), divider cleared to 0.
REQ-023 SCAN->MANUAL: next cycle ch_out = sel; divider cleared to 0.
REQ-024 FROZEN: data_out, ch_out, sel_err and divider count hold; step = 0; data_in changes ignored.
REQ-025 Leaving FROZEN into SCAN resumes from the retained divider count and channel; leaving it into MANUAL applies REQ-015 on the next edge.
REQ-026 A hold asserted in the same cycle as a divider wrap suppresses the advance and the step pulse.

Reset
REQ-027 Resetn=0 at a clock edge: state = MANUAL, ch_out = 0, data_out = 0, step = 0, sel_err = 0, divider = 0; this overrides hold and mode.
REQ-028 Reset mid-scan discards the scan position; the first edge after release evaluates REQ-021 normally.

Configuration
REQ-029 Macro MUX_SCAN_SEL_AUTOSCAN_EN defined: SCAN state, divider and step logic present as specified.
REQ-030 Macro undefined: mode ignored, SCAN unreachable, no divider, step tied 0; MANUAL and FROZEN behave identically to the defined case.

Structure
REQ-031 Package mux_scan_pkg: FSM state enum (MANUAL, SCAN, FROZEN) and a clog2-based select-width function.
REQ-032 Sub-module scan_tick_div: SCAN_DIV divider with clear and enable inputs and a tick output; instantiated only under MUX_SCAN_SEL_AUTOSCAN_EN.
REQ-033 Channel extraction from data_in is an indexed part-select, not a per-channel sum of products.

Verification (W=2, N=4, SCAN_DIV=4, macro defined unless stated)
REQ-034 Reset, then mode=0, sel=2, data_in=8'b11_10_01_00 -> one cycle later data_out=2'b10, ch_out=2, sel_err=0.
REQ-035 mode=1 from sel=3 -> ch_out 3,0,1,2 at 4-cycle intervals; step pulses once per advance; data_out equals the live channel data.
REQ-036 N=3, mode=0, sel=3 -> data_out=0, sel_err=1; sel=1 -> sel_err=0 the next cycle.
REQ-037 In SCAN, hold=1 on a wrap cycle for 5 cycles -> no step, ch_out and data_out frozen despite data_in toggling; on release the scan resumes from the retained count.
REQ-038 Resetn=0 for one cycle during SCAN with hold=1 -> all outputs 0, state MANUAL on the next edge.
REQ-039 Macro undefined, mode=1, sel=1 -> behaves as MANUAL: ch_out=1, step never asserts.
